mem_bus_responder: RTL

- Memory-side responder for the CPU's load/store path: a word-addressed data store behind a request/response valid/ready handshake.
- Services one outstanding request at a time with a programmable access latency, byte-lane write strobes and an error response.
- Gives the core a target whose timing is not single-cycle, so stall-capable load/store logic can be built and checked against it.

---
 rtl/mem_bus_responder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_responder.sv
// Word-addressed data store behind a valid/ready request/response handshake.
// One outstanding request, programmable access latency, byte strobes, error response.
module mem_bus_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    if (DEPTH < 4 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mem_bus_responder: DEPTH must be a power of two in 4..65536");
    end
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_lat
        $error("mem_bus_responder: LATENCY must be in 0..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic [31:0] mem_q [DEPTH];

    logic          accept;
    logic          enter_resp;
    logic          addr_err;
    logic          mem_we;
    logic [AW-1:0] idx;

    assign idx        = addr_q[AW+1:2];
    assign addr_err   = (addr_q[1:0] != 2'b00) ||
                        ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
    assign accept     = (state_q == IDLE) && req_valid && req_ready_q;
    assign enter_resp = (state_q == WAIT) && (cnt_q == 4'd0);
    assign mem_we     = enter_resp && write_q && !addr_err;

    // WAIT always spans LATENCY+1 edges so the response follows accept
    // by LATENCY+1 edges, including the LATENCY=0 case.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        unique case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    write_d     = req_write;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    wstrb_d     = req_wstrb;
                    req_ready_d = 1'b0;
                    cnt_d       = LAT_INIT;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = addr_err;
                    rsp_rdata_d = (!write_q && !addr_err) ? mem_q[idx] : 32'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    // Storage is never cleared; reset only blocks writes via the FSM state.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (wstrb_q[k]) begin
                    mem_q[idx][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
